// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_WORD_SIZE / UART_CLKS_PER_BIT : default frame format, also used by the TX framer
//   rx_state_t                         : receive framer states
package uart_pkg;
   localparam int UART_WORD_SIZE    = 8;
   localparam int UART_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_frame_if.sv
// Word-side interface of the UART receive framer.
//   rx_data   : received word, stable while rx_valid is high
//   rx_valid  : rx_data holds an unconsumed word
//   rx_ready  : consumer accepts; transfer on rx_valid & rx_ready
//   frame_err : 1-cycle pulse, stop bit low, word discarded
//   overrun   : 1-cycle pulse, word completed while holding register full, word dropped
// master = framer side, slave = consumer side.
interface uart_rx_frame_if
   import uart_pkg::*;
#(
   parameter int word_size = UART_WORD_SIZE
);
   logic [word_size-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;

   modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
   modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_frame_sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous inputs.
//   clk : destination clock
//   rst : synchronous active-high reset, both flops load rst_val
//   d   : asynchronous input
//   q   : synchronized output, 2-cycle latency
module sync_2ff #(
   parameter logic rst_val = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= rst_val;
         q    <= rst_val;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronizes the serial line, detects the start bit,
// samples data bits at mid-bit, checks the stop bit and presents each good
// word on a valid/ready holding register. Format: 1 start, word_size data
// bits (LSB first), 1 stop, no parity.
//   internal_clk : single clock, rising edge
//   internal_rst : synchronous active-high reset
//   bit_to_UART  : asynchronous serial line, idles high
//   rx           : word-side interface (rx_data/rx_valid/rx_ready/frame_err/overrun)
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int word_size    = UART_WORD_SIZE,
   parameter int clks_per_bit = UART_CLKS_PER_BIT
) (
   input  logic            internal_clk,
   input  logic            internal_rst,
   input  logic            bit_to_UART,
   uart_rx_frame_if.master rx
);
   localparam int CW = $clog2(clks_per_bit);
   localparam int IW = $clog2(word_size);
   localparam logic [CW-1:0] CNT_HALF = CW'(clks_per_bit / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(clks_per_bit - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(word_size - 1);

   rx_state_t            state, state_n;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [word_size-1:0] shift;
   logic                 line_s;
   logic                 cnt_clr, idx_clr, shift_en, word_done, stop_bad;

   sync_2ff #(.rst_val(1'b1)) u_sync (
      .clk (internal_clk),
      .rst (internal_rst),
      .d   (bit_to_UART),
      .q   (line_s)
   );

   always_ff @(posedge internal_clk) begin
      if (internal_rst) state <= IDLE;
      else              state <= state_n;
   end

   always_comb begin
      state_n   = state;
      cnt_clr   = 1'b0;
      idx_clr   = 1'b0;
      shift_en  = 1'b0;
      word_done = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!line_s) begin
               state_n = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            // Half-bit check rejects short low glitches and aligns
            // all later samples to the middle of each bit.
            if (cnt == CNT_HALF) begin
               cnt_clr = 1'b1;
               idx_clr = 1'b1;
               state_n = line_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_FULL) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (idx == IDX_LAST) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == CNT_FULL) begin
               cnt_clr = 1'b1;
               if (line_s) begin
                  word_done = 1'b1;
                  state_n   = IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_n  = BREAK;
               end
            end
         end
         BREAK: begin
            // A low stop bit may be a break; wait for the line to
            // return high before hunting for a new start bit.
            if (line_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Bit timing counter runs only while inside a frame.
   always_ff @(posedge internal_clk) begin
      if (internal_rst)                        cnt <= '0;
      else if (cnt_clr)                        cnt <= '0;
      else if (state != IDLE && state != BREAK) cnt <= cnt + 1'b1;
   end

   always_ff @(posedge internal_clk) begin
      if (internal_rst)                      idx <= '0;
      else if (idx_clr)                      idx <= '0;
      else if (shift_en && idx != IDX_LAST)  idx <= idx + 1'b1;
   end

   // LSB arrives first: insert at the top, shift right.
   always_ff @(posedge internal_clk) begin
      if (internal_rst)  shift <= '0;
      else if (shift_en) shift <= {line_s, shift[word_size-1:1]};
   end

   // Holding register. A consume in the completion cycle frees the slot,
   // so the new word replaces the old one without an overrun.
   always_ff @(posedge internal_clk) begin
      if (internal_rst) begin
         rx.rx_data   <= '0;
         rx.rx_valid  <= 1'b0;
         rx.frame_err <= 1'b0;
         rx.overrun   <= 1'b0;
      end else begin
         rx.frame_err <= stop_bad;
         rx.overrun   <= 1'b0;
         if (word_done) begin
            if (!rx.rx_valid || rx.rx_ready) begin
               rx.rx_data  <= shift;
               rx.rx_valid <= 1'b1;
            end else begin
               rx.overrun  <= 1'b1;
            end
         end else if (rx.rx_valid && rx.rx_ready) begin
            rx.rx_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame (word_size 8, clks_per_bit 16).
// Frames are driven bit-by-bit on the pin; a negedge monitor logs transfers
// and error pulses, and checks compare them with what the frame rules imply.
module tb_uart_rx_frame;
   localparam int BIT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic line = 1'b1;

   uart_rx_frame_if #(.word_size(8)) rx_if ();

   uart_rx_frame #(.word_size(8), .clks_per_bit(BIT)) dut (
      .internal_clk (clk),
      .internal_rst (rst),
      .bit_to_UART  (line),
      .rx           (rx_if)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // monitor state
   int         cyc = 0;
   logic [7:0] got_q[$];
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   int         both_cnt = 0;
   int         vhi_cnt = 0;
   int         rise_cyc = 0;
   logic       prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
      if (rx_if.frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_if.overrun) ovr_cnt <= ovr_cnt + 1;
      if (rx_if.frame_err && rx_if.overrun) both_cnt <= both_cnt + 1;
      if (rx_if.rx_valid) vhi_cnt <= vhi_cnt + 1;
      if (rx_if.rx_valid && !prev_valid) rise_cyc <= cyc;
      prev_valid <= rx_if.rx_valid;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic hold(input logic v, input int n);
      line = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) hold(d[i], BIT);
      hold(stop_b, BIT);
   endtask

   // One frame with consumer ready; expectations come from the caller.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_b,
                            input int low_extra, input int gap, input int exp_words,
                            input logic [7:0] exp_data, input int exp_ferr);
      int q0, f0, o0, v0, start;
      q0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = vhi_cnt; start = cyc;
      send_frame(d, stop_b);
      if (low_extra > 0) hold(1'b0, low_extra);
      hold(1'b1, gap);
      chk({tag, "_words"}, got_q.size() - q0, exp_words);
      if (exp_words > 0 && got_q.size() > q0) begin
         chk({tag, "_data"}, got_q[q0], exp_data);
         chk_rng({tag, "_latency"}, rise_cyc - start, 154, 156);
         chk({tag, "_pulse"}, vhi_cnt - v0, 1);
      end
      chk({tag, "_ferr"}, ferr_cnt - f0, exp_ferr);
      chk({tag, "_ovr"}, ovr_cnt - o0, 0);
   endtask

   typedef struct {
      string      tag;
      logic [7:0] data;
      logic       stop_b;
      int         low_extra;
      int         exp_words;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int q0, o0, f0, k;
      logic [7:0] d;
      logic sb;

      vecs[0] = '{"a5",     8'hA5, 1'b1,  0, 1, 8'hA5, 0};
      vecs[1] = '{"3c",     8'h3C, 1'b1,  0, 1, 8'h3C, 0};
      vecs[2] = '{"3c_bad", 8'h3C, 1'b0, 40, 0, 8'h00, 1};
      vecs[3] = '{"81",     8'h81, 1'b1,  0, 1, 8'h81, 0};
      vecs[4] = '{"00",     8'h00, 1'b1,  0, 1, 8'h00, 0};
      vecs[5] = '{"ff",     8'hFF, 1'b1,  0, 1, 8'hFF, 0};

      rx_if.rx_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_data", rx_if.rx_data, 0);
      chk("rst_valid", rx_if.rx_valid, 0);
      chk("rst_ferr", rx_if.frame_err, 0);
      chk("rst_ovr", rx_if.overrun, 0);
      hold(1'b1, 10);

      // First table entry before the glitch, then glitch, then the rest.
      run_frame(vecs[0].tag, vecs[0].data, vecs[0].stop_b, vecs[0].low_extra, 20,
                vecs[0].exp_words, vecs[0].exp_data, vecs[0].exp_ferr);

      // Short low glitch on idle line.
      q0 = got_q.size(); f0 = ferr_cnt;
      hold(1'b0, 4);
      hold(1'b1, 40);
      chk("glitch_words", got_q.size() - q0, 0);
      chk("glitch_ferr", ferr_cnt - f0, 0);

      for (int i = 1; i < 6; i++)
         run_frame(vecs[i].tag, vecs[i].data, vecs[i].stop_b, vecs[i].low_extra, 20,
                   vecs[i].exp_words, vecs[i].exp_data, vecs[i].exp_ferr);

      // Overrun: two words with no consumer.
      rx_if.rx_ready = 1'b0;
      q0 = got_q.size(); o0 = ovr_cnt;
      send_frame(8'h11, 1'b1);
      hold(1'b1, 4);
      send_frame(8'h22, 1'b1);
      hold(1'b1, 10);
      chk("ovr_data", rx_if.rx_data, 8'h11);
      chk("ovr_valid", rx_if.rx_valid, 1);
      chk("ovr_pulses", ovr_cnt - o0, 1);
      chk("ovr_no_xfer", got_q.size() - q0, 0);
      rx_if.rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rx_if.rx_ready = 1'b0;
      chk("ovr_drain_words", got_q.size() - q0, 1);
      if (got_q.size() > q0) chk("ovr_drain_data", got_q[q0], 8'h11);
      chk("ovr_drain_valid", rx_if.rx_valid, 0);

      // Consume in the stop-sample cycle of the second word.
      q0 = got_q.size(); o0 = ovr_cnt;
      send_frame(8'h11, 1'b1);
      hold(1'b1, 4);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1 rx_if.rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_if.rx_ready = 1'b0;
         end
      join
      hold(1'b1, 10);
      chk("swap_words", got_q.size() - q0, 1);
      if (got_q.size() > q0) chk("swap_xfer_data", got_q[q0], 8'h11);
      chk("swap_data", rx_if.rx_data, 8'h22);
      chk("swap_valid", rx_if.rx_valid, 1);
      chk("swap_ovr", ovr_cnt - o0, 0);

      // Reset mid-frame while a word is still held.
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (80) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            chk("mid_rst_data", rx_if.rx_data, 0);
            chk("mid_rst_valid", rx_if.rx_valid, 0);
            chk("mid_rst_ferr", rx_if.frame_err, 0);
            chk("mid_rst_ovr", rx_if.overrun, 0);
         end
      join
      rx_if.rx_ready = 1'b1;
      hold(1'b1, 20);
      run_frame("after_rst", 8'h5A, 1'b1, 0, 20, 1, 8'h5A, 0);

      // Random frames: good stop -> word equals the byte sent,
      // bad stop -> no word and one frame error.
      for (int i = 0; i < 25; i++) begin
         d  = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 4) != 0);
         k  = sb ? 0 : $urandom_range(0, 30);
         run_frame($sformatf("rnd%0d", i), d, sb, k, $urandom_range(4, 20),
                   sb ? 1 : 0, d, sb ? 0 : 1);
      end

      chk("err_overlap", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
